// File: rtl/mem_route_pkg.sv
// Shared definitions for the crossbar return path: index widths, slave index type
// and the round-robin priority update used by both the crossbar and the router.
package mem_route_pkg;

   localparam int MAX_SIDX_W = 16;

   typedef logic [MAX_SIDX_W-1:0] slave_idx_t;

   // Index width for a port count; a single port still needs one bit.
   function automatic int sidx_w(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

   // Priority moves to the port just after the winner, wrapping at the port count.
   function automatic int next_priority(input int winner, input int ports);
      return (winner + 1 >= ports) ? 0 : winner + 1;
   endfunction

endpackage

// File: rtl/mem_tag_fifo.sv
// In-order tag FIFO for one memory master: records the slave index of every
// forwarded read so the matching response can be routed back.
module mem_tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             push_fire;
   logic             pop_fire;

   // Both flags come from the registered count only: no bypass, and a pop in
   // the same cycle never frees a slot for a push.
   assign push_ready = (count_reg != CNT_W'(DEPTH));
   assign pop_valid  = (count_reg != '0);
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = pop_valid && pop_ready;
   assign pop_data   = mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({push_fire, pop_fire})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/mem_response_router.sv
// Return-path router: pops each master's tag FIFO on a response, arbitrates
// round-robin per destination slave and registers the winning beat.
module mem_response_router
   import mem_route_pkg::*;
#(
   parameter int SLAVE_PORTS  = 1,
   parameter int MASTER_PORTS = 1,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4,
   parameter int ADDR_WIDTH   = 32,
   localparam int SIDX_W      = sidx_w(SLAVE_PORTS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [MASTER_PORTS-1:0]        track_valid,
   output logic [MASTER_PORTS-1:0]        track_ready,
   input  logic [MASTER_PORTS*SIDX_W-1:0] track_slave,
   input  logic [MASTER_PORTS-1:0]        responses_valid,
   output logic [MASTER_PORTS-1:0]        responses_ready,
   input  logic [MASTER_PORTS*DATA_WIDTH-1:0] responses_data,
   output logic [SLAVE_PORTS-1:0]         returns_valid,
   input  logic [SLAVE_PORTS-1:0]         returns_ready,
   output logic [SLAVE_PORTS*DATA_WIDTH-1:0] returns_data,
   output logic [SLAVE_PORTS-1:0]         returns_read_enable,
   output logic [SLAVE_PORTS-1:0]         returns_write_enable,
   output logic [SLAVE_PORTS*ADDR_WIDTH-1:0] returns_addr
);

   localparam int MIDX_W = sidx_w(MASTER_PORTS);

   logic [SIDX_W-1:0]       head [MASTER_PORTS];
   logic [MASTER_PORTS-1:0] tag_avail;
   logic [DATA_WIDTH-1:0]   resp_data [MASTER_PORTS];
   logic [MASTER_PORTS-1:0] grant [SLAVE_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < MASTER_PORTS; gi++) begin : g_master
         assign resp_data[gi] = responses_data[gi*DATA_WIDTH +: DATA_WIDTH];

         mem_tag_fifo #(
            .WIDTH(SIDX_W),
            .DEPTH(DEPTH)
         ) u_tag_fifo (
            .clk       (clk),
            .rst       (rst),
            .push_valid(track_valid[gi]),
            .push_ready(track_ready[gi]),
            .push_data (track_slave[gi*SIDX_W +: SIDX_W]),
            .pop_valid (tag_avail[gi]),
            .pop_ready (responses_ready[gi]),
            .pop_data  (head[gi])
         );

         // An out-of-range tag would stall this master forever.
         a_tag_in_range: assert property (@(posedge clk) disable iff (!rst)
            (track_valid[gi] && track_ready[gi]) |->
            (slave_idx_t'(track_slave[gi*SIDX_W +: SIDX_W]) < slave_idx_t'(SLAVE_PORTS)));
      end
   endgenerate

   // A master's head tag selects exactly one slave, so at most one grant per master.
   always_comb begin
      responses_ready = '0;
      for (int j = 0; j < SLAVE_PORTS; j++) begin
         responses_ready = responses_ready | grant[j];
      end
   end

   generate
      for (gi = 0; gi < SLAVE_PORTS; gi++) begin : g_slave
         logic [MASTER_PORTS-1:0] cand;
         logic [MASTER_PORTS-1:0] grant_local;
         logic [MIDX_W-1:0]       prio_reg;
         logic [MIDX_W-1:0]       winner;
         logic                    found;
         logic                    load_en;
         logic                    out_valid_reg;
         logic [DATA_WIDTH-1:0]   out_data_reg;

         always_comb begin
            cand = '0;
            for (int i = 0; i < MASTER_PORTS; i++) begin
               cand[i] = responses_valid[i] && tag_avail[i] &&
                         (slave_idx_t'(head[i]) == slave_idx_t'(gi));
            end
         end

         // Scan from the highest offset down so the nearest candidate at or
         // after prio_reg is the one left standing.
         always_comb begin
            int idx;
            found  = 1'b0;
            winner = prio_reg;
            idx    = 0;
            for (int k = MASTER_PORTS - 1; k >= 0; k--) begin
               idx = (int'(prio_reg) + k) % MASTER_PORTS;
               if (cand[idx]) begin
                  found  = 1'b1;
                  winner = MIDX_W'(idx);
               end
            end
         end

         assign load_en = !out_valid_reg || returns_ready[gi];

         always_comb begin
            grant_local = '0;
            for (int i = 0; i < MASTER_PORTS; i++) begin
               grant_local[i] = found && load_en && (winner == MIDX_W'(i));
            end
         end

         assign grant[gi] = grant_local;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               out_valid_reg <= 1'b0;
               out_data_reg  <= '0;
               prio_reg      <= '0;
            end else if (load_en) begin
               if (found) begin
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= resp_data[winner];
                  prio_reg      <= MIDX_W'(next_priority(int'(winner), MASTER_PORTS));
               end else begin
                  out_valid_reg <= 1'b0;
               end
            end
         end

         assign returns_valid[gi]                               = out_valid_reg;
         assign returns_data[gi*DATA_WIDTH +: DATA_WIDTH]       = out_data_reg;
         assign returns_read_enable[gi]                         = 1'b0;
         assign returns_write_enable[gi]                        = 1'b0;
         assign returns_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]       = '0;
      end
   endgenerate

endmodule

// File: tb/tb_mem_response_router.sv
// Directed table-driven bench for a 2-slave x 2-master router with DEPTH 4.
module tb_mem_response_router;

   logic        clk;
   logic        rst;
   logic [1:0]  track_valid;
   logic [1:0]  track_ready;
   logic [1:0]  track_slave;
   logic [1:0]  responses_valid;
   logic [1:0]  responses_ready;
   logic [63:0] responses_data;
   logic [1:0]  returns_valid;
   logic [1:0]  returns_ready;
   logic [63:0] returns_data;
   logic [1:0]  returns_read_enable;
   logic [1:0]  returns_write_enable;
   logic [63:0] returns_addr;

   int checks = 0;
   int errors = 0;

   mem_response_router #(
      .SLAVE_PORTS (2),
      .MASTER_PORTS(2),
      .DATA_WIDTH  (32),
      .DEPTH       (4),
      .ADDR_WIDTH  (32)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .track_valid         (track_valid),
      .track_ready         (track_ready),
      .track_slave         (track_slave),
      .responses_valid     (responses_valid),
      .responses_ready     (responses_ready),
      .responses_data      (responses_data),
      .returns_valid       (returns_valid),
      .returns_ready       (returns_ready),
      .returns_data        (returns_data),
      .returns_read_enable (returns_read_enable),
      .returns_write_enable(returns_write_enable),
      .returns_addr        (returns_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  tv;
      logic [1:0]  ts;
      logic [1:0]  rv;
      logic [63:0] rd;
      logic [1:0]  rr;
      logic [1:0]  e_tr;
      logic [1:0]  e_rsr;
      logic [1:0]  e_rtv;
      logic [63:0] e_rtd;
   } vec_t;

   localparam int NVEC = 28;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setv(input int k, input logic [1:0] tv, input logic [1:0] ts,
                       input logic [1:0] rv, input logic [31:0] d1, input logic [31:0] d0,
                       input logic [1:0] rr, input logic [1:0] e_tr, input logic [1:0] e_rsr,
                       input logic [1:0] e_rtv, input logic [31:0] q1, input logic [31:0] q0);
      vecs[k] = '{tv, ts, rv, {d1, d0}, rr, e_tr, e_rsr, e_rtv, {q1, q0}};
   endtask

   initial begin
      rst             = 1'b0;
      track_valid     = '0;
      track_slave     = '0;
      responses_valid = '0;
      responses_data  = '0;
      returns_ready   = 2'b11;

      //      k  tv     ts     rv     d1     d0           rr     e_tr   e_rsr  e_rtv  q1     q0
      setv( 0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0);
      setv( 1, 2'b01, 2'b00, 2'b01, 32'h0, 32'hAAAA,     2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0);
      setv( 2, 2'b00, 2'b00, 2'b01, 32'h0, 32'hDEADBEEF, 2'b11, 2'b11, 2'b01, 2'b00, 32'h0, 32'h0);
      setv( 3, 2'b00, 2'b00, 2'b01, 32'h0, 32'h1234,     2'b11, 2'b11, 2'b00, 2'b01, 32'h0, 32'hDEADBEEF);
      setv( 4, 2'b11, 2'b01, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'hDEADBEEF);
      setv( 5, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'hDEADBEEF);
      setv( 6, 2'b00, 2'b00, 2'b11, 32'h33, 32'h11,      2'b11, 2'b11, 2'b11, 2'b00, 32'h0, 32'hDEADBEEF);
      setv( 7, 2'b00, 2'b00, 2'b01, 32'h0, 32'h22,       2'b11, 2'b11, 2'b01, 2'b11, 32'h11, 32'h33);
      setv( 8, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b01, 32'h11, 32'h22);
      setv( 9, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h11, 32'h22);
      setv(10, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h11, 32'h22);
      setv(11, 2'b00, 2'b00, 2'b11, 32'hB0, 32'hA0,      2'b11, 2'b11, 2'b10, 2'b00, 32'h11, 32'h22);
      setv(12, 2'b00, 2'b00, 2'b11, 32'hB1, 32'hA0,      2'b11, 2'b11, 2'b01, 2'b01, 32'h11, 32'hB0);
      setv(13, 2'b00, 2'b00, 2'b11, 32'hB1, 32'hA1,      2'b11, 2'b11, 2'b10, 2'b01, 32'h11, 32'hA0);
      setv(14, 2'b00, 2'b00, 2'b11, 32'hB2, 32'hA1,      2'b00, 2'b11, 2'b00, 2'b01, 32'h11, 32'hB1);
      setv(15, 2'b00, 2'b00, 2'b11, 32'hB2, 32'hA1,      2'b00, 2'b11, 2'b00, 2'b01, 32'h11, 32'hB1);
      setv(16, 2'b00, 2'b00, 2'b11, 32'hB2, 32'hA1,      2'b00, 2'b11, 2'b00, 2'b01, 32'h11, 32'hB1);
      setv(17, 2'b00, 2'b00, 2'b11, 32'hB2, 32'hA1,      2'b01, 2'b11, 2'b01, 2'b01, 32'h11, 32'hB1);
      setv(18, 2'b00, 2'b00, 2'b11, 32'hB2, 32'hA2,      2'b11, 2'b11, 2'b10, 2'b01, 32'h11, 32'hA1);
      setv(19, 2'b00, 2'b00, 2'b01, 32'h0, 32'hA2,       2'b11, 2'b11, 2'b01, 2'b01, 32'h11, 32'hB2);
      setv(20, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b01, 32'h11, 32'hA2);
      setv(21, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h11, 32'hA2);
      setv(22, 2'b10, 2'b10, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h11, 32'hA2);
      setv(23, 2'b10, 2'b10, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h11, 32'hA2);
      setv(24, 2'b10, 2'b10, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h11, 32'hA2);
      setv(25, 2'b10, 2'b10, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 32'h11, 32'hA2);
      setv(26, 2'b10, 2'b10, 2'b10, 32'hC0, 32'h0,       2'b11, 2'b01, 2'b10, 2'b00, 32'h11, 32'hA2);
      setv(27, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        2'b11, 2'b11, 2'b00, 2'b10, 32'hC0, 32'hA2);

      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < NVEC; k++) begin
         @(negedge clk);
         track_valid     = vecs[k].tv;
         track_slave     = vecs[k].ts;
         responses_valid = vecs[k].rv;
         responses_data  = vecs[k].rd;
         returns_ready   = vecs[k].rr;
         #1;
         $display("step %0d: track_ready=%b resp_ready=%b ret_valid=%b ret_data=%h",
                  k, track_ready, responses_ready, returns_valid, returns_data);
         check($sformatf("s%0d_track_ready", k), 64'(track_ready), 64'(vecs[k].e_tr));
         check($sformatf("s%0d_resp_ready", k), 64'(responses_ready), 64'(vecs[k].e_rsr));
         check($sformatf("s%0d_ret_valid", k), 64'(returns_valid), 64'(vecs[k].e_rtv));
         check($sformatf("s%0d_ret_data", k), returns_data, vecs[k].e_rtd);
      end
      check("tied_rd_wr_en", 64'({returns_read_enable, returns_write_enable}), 64'h0);
      check("tied_addr", returns_addr, 64'h0);

      // Asynchronous reset while master1 holds three tags and slave1 has a beat.
      #2;
      responses_valid = 2'b10;
      rst             = 1'b0;
      #1;
      $display("async reset: track_ready=%b resp_ready=%b ret_valid=%b ret_data=%h",
               track_ready, responses_ready, returns_valid, returns_data);
      check("rst_ret_valid", 64'(returns_valid), 64'h0);
      check("rst_ret_data", returns_data, 64'h0);
      check("rst_track_ready", 64'(track_ready), 64'h3);
      check("rst_resp_ready", 64'(responses_ready), 64'h0);

      @(negedge clk);
      rst             = 1'b1;
      track_valid     = 2'b01;
      track_slave     = 2'b00;
      responses_valid = 2'b11;
      responses_data  = {32'h77, 32'h66};
      #1;
      $display("post reset push: track_ready=%b resp_ready=%b", track_ready, responses_ready);
      check("post_rst_resp_ready", 64'(responses_ready), 64'h0);
      check("post_rst_track_ready", 64'(track_ready), 64'h3);

      @(negedge clk);
      track_valid     = 2'b00;
      responses_valid = 2'b01;
      responses_data  = {32'h0, 32'h5A};
      #1;
      $display("post reset response: resp_ready=%b ret_valid=%b", responses_ready, returns_valid);
      check("post_rst_pop", 64'(responses_ready), 64'h1);
      check("post_rst_no_beat", 64'(returns_valid), 64'h0);

      @(negedge clk);
      responses_valid = 2'b00;
      #1;
      $display("post reset return: ret_valid=%b ret_data=%h", returns_valid, returns_data);
      check("post_rst_ret_valid", 64'(returns_valid), 64'h1);
      check("post_rst_ret_data", 64'(returns_data[31:0]), 64'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
